hmmm_muldiv: RTL and testbench

- Multi-cycle signed multiply/divide/modulo unit for the ConfusedCore HMMM datapath.
- Sits directly upstream of the register file's write port: the execute stage issues operands read from rd1/rd2 plus the destination register, and the unit later produces one write (we/wa/wd) for the regfile write-port mux.
- Serves the HMMM mul, div and mod instructions; iterative, one operation in flight.

---
 rtl/hmmm_muldiv.sv | 169 ++++++++++++++++
 tb/tb_hmmm_muldiv.sv | 139 +++++++++++++
 2 files changed

// File: rtl/hmmm_muldiv.sv
// Iterative signed multiply/divide/modulo unit for the HMMM datapath.
// Produces one register-file write (we/wa/wd) for each accepted operation.
module hmmm_muldiv #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [AW-1:0]    dest,
  input  logic             flush,
  output logic             busy,
  output logic             we,
  output logic [AW-1:0]    wa,
  output logic [WIDTH-1:0] wd,
  output logic             err
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_MOD = 2'b10;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, WB} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q;
  logic [1:0]        op_q;
  logic [AW-1:0]     dest_q;
  logic [WIDTH-1:0]  acc_q;   // mul product / div remainder
  logic [WIDTH-1:0]  opa_q;   // mul multiplicand / div dividend shifting into quotient
  logic [WIDTH-1:0]  opb_q;   // mul multiplier / divisor
  logic              rneg_q;
  logic              aneg_q;

  logic              we_d, err_d;
  logic [AW-1:0]     wa_d;
  logic [WIDTH-1:0]  wd_d;

  logic              accept_c;
  logic              bad_c;
  logic [WIDTH:0]    shl_c;
  logic [WIDTH:0]    diff_c;
  logic [WIDTH-1:0]  sum_c;
  logic [WIDTH-1:0]  result_c;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? neg(x) : x;
  endfunction

  assign accept_c = start && !flush && (state_q == IDLE);
  assign bad_c    = (op == 2'b11) || ((op != OP_MUL) && (b == '0));

  // One shift-add or restoring-division step
  assign sum_c  = acc_q + (opb_q[0] ? opa_q : '0);
  assign shl_c  = {acc_q, opa_q[WIDTH-1]};
  assign diff_c = shl_c - {1'b0, opb_q};

  // Sign correction applied in SIGN
  always_comb begin
    result_c = '0;
    case (op_q)
      OP_MUL:  result_c = rneg_q ? neg(acc_q) : acc_q;
      OP_DIV:  result_c = rneg_q ? neg(opa_q) : opa_q;
      OP_MOD:  result_c = aneg_q ? neg(acc_q) : acc_q;
      default: result_c = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept_c) state_d = bad_c ? WB : CALC;
      CALC: begin
        if (flush)                           state_d = IDLE;
        else if (count_q == CW'(WIDTH - 1))  state_d = SIGN;
      end
      SIGN: state_d = flush ? IDLE : WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values; r0 is hardwired, so writes to it are suppressed
  always_comb begin
    we_d  = 1'b0;
    err_d = 1'b0;
    wa_d  = wa;
    wd_d  = wd;
    if (accept_c && bad_c) begin
      we_d  = (dest != '0);
      err_d = (dest != '0);
      wa_d  = dest;
      wd_d  = '0;
    end else if (state_q == SIGN && !flush) begin
      we_d  = (dest_q != '0);
      wa_d  = dest_q;
      wd_d  = result_c;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      we   <= 1'b0;
      err  <= 1'b0;
      wa   <= '0;
      wd   <= '0;
    end else begin
      busy <= (state_d != IDLE);
      we   <= we_d;
      err  <= err_d;
      wa   <= wa_d;
      wd   <= wd_d;
    end
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      op_q    <= '0;
      dest_q  <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rneg_q  <= 1'b0;
      aneg_q  <= 1'b0;
    end else if (accept_c) begin
      count_q <= '0;
      op_q    <= op;
      dest_q  <= dest;
      acc_q   <= '0;
      opa_q   <= mag(a);
      opb_q   <= mag(b);
      rneg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
      aneg_q  <= a[WIDTH-1];
    end else if (state_q == CALC) begin
      count_q <= count_q + CW'(1);
      if (op_q == OP_MUL) begin
        acc_q <= sum_c;
        opa_q <= {opa_q[WIDTH-2:0], 1'b0};
        opb_q <= {1'b0, opb_q[WIDTH-1:1]};
      end else if (!diff_c[WIDTH]) begin
        acc_q <= diff_c[WIDTH-1:0];
        opa_q <= {opa_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_q <= shl_c[WIDTH-1:0];
        opa_q <= {opa_q[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_hmmm_muldiv.sv
// Directed self-checking bench for hmmm_muldiv.
module tb_hmmm_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a, b;
  logic [3:0]  dest;
  logic        flush;
  logic        busy, we, err;
  logic [3:0]  wa;
  logic [15:0] wd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  hmmm_muldiv #(.WIDTH(16), .AW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .dest(dest), .flush(flush), .busy(busy), .we(we), .wa(wa), .wd(wd),
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present a request and return just after the accepting edge
  task automatic issue(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic [3:0] d);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; dest = d;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  // Wait (bounded) for the write and check latency and payload
  task automatic wait_wb(input string tag, input logic [3:0] ewa, input logic [15:0] ewd,
                         input logic eerr, input int elat);
    while (we !== 1'b1 && (cyc - t0) < 40) begin
      @(posedge clk); #1;
    end
    chk({tag, "_we"},  32'(we), 32'd1);
    chk({tag, "_lat"}, 32'(cyc - t0), 32'(elat));
    chk({tag, "_wa"},  32'(wa), 32'(ewa));
    chk({tag, "_wd"},  32'(wd), 32'(ewd));
    chk({tag, "_err"}, 32'(err), 32'(eerr));
    @(posedge clk); #1;
    chk({tag, "_idle"}, {30'd0, busy, we}, 32'd0);
  endtask

  initial begin
    int busy_cnt;
    int we_cnt;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; dest = '0; flush = 1'b0;
    #2;
    chk("rst_out", {busy, we, err, wa, wd}, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Main arithmetic
    issue(2'b00, 16'h0007, 16'hFFFD, 4'd5); wait_wb("mul_neg", 4'd5, 16'hFFEB, 1'b0, 17);
    issue(2'b01, 16'hFFF9, 16'h0002, 4'd3); wait_wb("div_neg", 4'd3, 16'hFFFD, 1'b0, 17);
    issue(2'b10, 16'hFFF9, 16'h0002, 4'd3); wait_wb("mod_neg", 4'd3, 16'hFFFF, 1'b0, 17);
    issue(2'b10, 16'h0007, 16'hFFFE, 4'd4); wait_wb("mod_pos", 4'd4, 16'h0001, 1'b0, 17);
    issue(2'b01, 16'h0064, 16'h0007, 4'd9); wait_wb("div_pos", 4'd9, 16'h000E, 1'b0, 17);

    // Error paths
    issue(2'b01, 16'h0005, 16'h0000, 4'd2); wait_wb("div_zero", 4'd2, 16'h0000, 1'b1, 0);
    issue(2'b11, 16'h0005, 16'h0003, 4'd6); wait_wb("op_rsvd", 4'd6, 16'h0000, 1'b1, 0);
    issue(2'b10, 16'h1234, 16'h0000, 4'd1); wait_wb("mod_zero", 4'd1, 16'h0000, 1'b1, 0);

    // Overflow wrap
    issue(2'b01, 16'h8000, 16'hFFFF, 4'd7); wait_wb("div_ovf", 4'd7, 16'h8000, 1'b0, 17);
    issue(2'b10, 16'h8000, 16'hFFFF, 4'd7); wait_wb("mod_ovf", 4'd7, 16'h0000, 1'b0, 17);
    issue(2'b00, 16'h0100, 16'h0100, 4'd8); wait_wb("mul_ovf", 4'd8, 16'h0000, 1'b0, 17);

    // Start while busy is ignored
    issue(2'b00, 16'h0007, 16'hFFFD, 4'd5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 16'h0050; b = 16'h0004; dest = 4'd9;
    @(negedge clk); start = 1'b0;
    wait_wb("busy_ign", 4'd5, 16'hFFEB, 1'b0, 17);

    // dest=0: full busy window, no write
    issue(2'b00, 16'h0003, 16'h0004, 4'd0);
    busy_cnt = 1; we_cnt = 0;
    repeat (24) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (we) we_cnt++;
    end
    chk("r0_busy", 32'(busy_cnt), 32'd18);
    chk("r0_we", 32'(we_cnt), 32'd0);

    // Flush at CALC count 7
    issue(2'b00, 16'h0003, 16'h0004, 4'd5);
    repeat (7) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    we_cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (we) we_cnt++;
    end
    chk("flush_we", 32'(we_cnt), 32'd0);

    // Flush and start in the same IDLE edge
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b11; dest = 4'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start", {30'd0, busy, we}, 32'd0);

    // Asynchronous reset mid-CALC, then a fresh op
    issue(2'b00, 16'h0005, 16'h0005, 4'd6);
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_out", {busy, we, err, wa, wd}, 32'd0);
    @(negedge clk); reset = 1'b0;
    issue(2'b00, 16'h0003, 16'h0004, 4'd7); wait_wb("post_rst", 4'd7, 16'h000C, 1'b0, 17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
